// File: rtl/rag_pool_pkg.sv
// Shared types and constants for the attention-masked mean pooler.
// Data is signed Q16.16; the pooler itself is scale-agnostic (mean of raw words).
package rag_pool_pkg;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_ACCUM  = 2'd1,
        P_DIVIDE = 2'd2,
        P_DONE   = 2'd3
    } pool_state_t;

    localparam int FRAC_BITS = 16;
    localparam int DATA_W    = 2 * FRAC_BITS;

    // Smallest accumulator that holds MAX_TOKENS signed DATA_W words without overflow.
    function automatic int acc_w_min(input int max_tokens);
        return DATA_W + $clog2(max_tokens) + 1;
    endfunction

endpackage

// File: rtl/pool_divider.sv
// Sequential restoring divider: |dividend| / divisor, truncated toward zero,
// sign re-applied. One load cycle, ACC_W iterations, done pulses for one cycle.
module pool_divider #(
    parameter int ACC_W = 48,
    parameter int DIV_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] dividend,
    input  logic        [DIV_W-1:0] divisor,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             quotient
);
    localparam int CNT_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0] mag_reg;
    logic [DIV_W-1:0] rem_reg;
    logic [DIV_W-1:0] div_reg;
    logic             neg_reg;
    logic [CNT_W-1:0] iter_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [DIV_W:0]   trial;
    logic             fits;

    // mag_reg shifts dividend bits out of the top and quotient bits in at the bottom.
    always_comb begin
        trial = {rem_reg, mag_reg[ACC_W-1]};
        fits  = trial >= {1'b0, div_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_reg  <= '0;
            rem_reg  <= '0;
            div_reg  <= '0;
            neg_reg  <= 1'b0;
            iter_reg <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                mag_reg  <= dividend[ACC_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
                neg_reg  <= dividend[ACC_W-1];
                div_reg  <= divisor;
                rem_reg  <= '0;
                iter_reg <= CNT_W'(ACC_W);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rem_reg  <= fits ? DIV_W'(trial - {1'b0, div_reg}) : trial[DIV_W-1:0];
                mag_reg  <= {mag_reg[ACC_W-2:0], fits};
                iter_reg <= iter_reg - CNT_W'(1);
                if (iter_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign quotient = neg_reg ? 32'(-mag_reg) : 32'(mag_reg);

endmodule

// File: rtl/embedding_mean_pooler.sv
// Element-serial masked mean pooling: accumulate unmasked token vectors, then
// divide each element by the token count through one shared serial divider.
module embedding_mean_pooler
    import rag_pool_pkg::*;
#(
    parameter int EMBEDDING_DIM = 384,
    parameter int MAX_TOKENS    = 512,
    parameter int ACC_W         = 48
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [31:0]                          s_data,
    input  logic                                 s_mask,
    input  logic                                 s_last,
    output logic [EMBEDDING_DIM-1:0][31:0]       pooled_embedding,
    output logic                                 done,
    output logic                                 busy,
    output logic [$clog2(MAX_TOKENS+1)-1:0]      token_count,
    output logic                                 protocol_err
);
    localparam int E_W  = (EMBEDDING_DIM > 1) ? $clog2(EMBEDDING_DIM) : 1;
    localparam int TC_W = $clog2(MAX_TOKENS + 1);
    localparam logic [E_W-1:0]  E_LAST = E_W'(EMBEDDING_DIM - 1);
    localparam logic [TC_W-1:0] TC_MAX = TC_W'(MAX_TOKENS);

    if (ACC_W < acc_w_min(MAX_TOKENS)) begin : g_acc_w_check
        $error("ACC_W too narrow for MAX_TOKENS");
    end

    pool_state_t state_reg, state_next;

    logic [E_W-1:0]          e_reg;
    logic                    mask_reg;
    logic [TC_W-1:0]         tc_reg;
    logic                    perr_reg;
    logic                    beat, at_last, eff_mask, zero_path;
    logic [TC_W-1:0]         tc_base, tc_next;
    logic signed [ACC_W-1:0] data_ext;
    logic                    acc_add, acc_clr, pool_wr, div_start;
    logic [31:0]             pool_val;
    logic                    div_busy, div_done;
    logic [31:0]             div_q;
    logic signed [ACC_W-1:0] acc_view [EMBEDDING_DIM];

    // A frame's first beat starts the count from zero; saturated tokens count as masked.
    always_comb begin
        at_last   = e_reg == E_LAST;
        tc_base   = (state_reg == P_IDLE) ? '0 : tc_reg;
        eff_mask  = (e_reg == '0) ? (s_mask && tc_base != TC_MAX) : mask_reg;
        tc_next   = (at_last && eff_mask) ? tc_base + TC_W'(1) : tc_base;
        zero_path = tc_reg == '0;
        data_ext  = {{(ACC_W-DATA_W){s_data[DATA_W-1]}}, s_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= P_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            P_IDLE:   if (beat) state_next = s_last ? P_DIVIDE : P_ACCUM;
            P_ACCUM:  if (beat && s_last) state_next = P_DIVIDE;
            P_DIVIDE: if (pool_wr && at_last) state_next = P_DONE;
            P_DONE:   state_next = P_IDLE;
            default:  state_next = P_IDLE;
        endcase
    end

    always_comb begin
        s_ready   = rst_n && (state_reg == P_IDLE || state_reg == P_ACCUM);
        beat      = s_valid && s_ready;
        busy      = state_reg != P_IDLE;
        done      = state_reg == P_DONE;
        acc_add   = beat && eff_mask;
        div_start = 1'b0;
        acc_clr   = 1'b0;
        pool_wr   = 1'b0;
        pool_val  = '0;
        if (state_reg == P_DIVIDE) begin
            if (zero_path) begin
                acc_clr = 1'b1;
                pool_wr = 1'b1;
            end else begin
                div_start = !div_busy && !div_done;
                acc_clr   = div_start;
                pool_wr   = div_done;
                pool_val  = div_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_reg    <= '0;
            mask_reg <= 1'b0;
            tc_reg   <= '0;
            perr_reg <= 1'b0;
        end else if (beat) begin
            e_reg    <= (s_last || at_last) ? '0 : e_reg + E_W'(1);
            if (e_reg == '0) mask_reg <= eff_mask;
            tc_reg   <= tc_next;
            perr_reg <= (state_reg != P_IDLE && perr_reg) || (s_last && !at_last);
        end else if (pool_wr) begin
            e_reg <= at_last ? '0 : e_reg + E_W'(1);
        end
    end

    for (genvar gi = 0; gi < EMBEDDING_DIM; gi++) begin : g_elem
        logic signed [ACC_W-1:0] acc_reg;
        logic [31:0]             pooled_reg;
        logic                    sel;

        assign sel = e_reg == E_W'(gi);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                acc_reg    <= '0;
                pooled_reg <= '0;
            end else begin
                if (acc_clr && sel)      acc_reg <= '0;
                else if (acc_add && sel) acc_reg <= acc_reg + data_ext;
                if (pool_wr && sel)      pooled_reg <= pool_val;
            end
        end

        assign acc_view[gi]         = acc_reg;
        assign pooled_embedding[gi] = pooled_reg;
    end

    pool_divider #(
        .ACC_W (ACC_W),
        .DIV_W (TC_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (acc_view[e_reg]),
        .divisor  (tc_reg),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    assign token_count  = tc_reg;
    assign protocol_err = perr_reg;

endmodule

// File: tb/tb_embedding_mean_pooler.sv
// Self-checking bench for embedding_mean_pooler (DIM=4): directed and random
// frames compared against a plain-arithmetic masked-mean reference.
module tb_embedding_mean_pooler;
    localparam int DIM   = 4;
    localparam int MAXT  = 512;
    localparam int ACCW  = 48;
    localparam int MAXF  = 600;
    localparam int LIMIT = 2000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [31:0]           s_data = '0;
    logic                  s_mask = 1'b0;
    logic                  s_last = 1'b0;
    logic [DIM-1:0][31:0]  pooled_embedding;
    logic                  done, busy, protocol_err;
    logic [9:0]            token_count;

    int n_cmp = 0;
    int n_fail = 0;

    int          fv [MAXF][DIM];
    bit          fm [MAXF];
    int          n_tok, last_len;
    logic [31:0] exp_pooled [DIM];
    int          exp_tc, exp_lat;
    bit          exp_perr;
    int          lat;
    logic        done_after;

    always #5 clk = ~clk;

    embedding_mean_pooler #(
        .EMBEDDING_DIM (DIM),
        .MAX_TOKENS    (MAXT),
        .ACC_W         (ACCW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_mask           (s_mask),
        .s_last           (s_last),
        .pooled_embedding (pooled_embedding),
        .done             (done),
        .busy             (busy),
        .token_count      (token_count),
        .protocol_err     (protocol_err)
    );

    task automatic set_tok(input int t, input int a, input int b, input int c, input int d, input bit m);
        fv[t][0] = a; fv[t][1] = b; fv[t][2] = c; fv[t][3] = d; fm[t] = m;
    endtask

    // Reference: mean over complete unmasked tokens (first MAXT only), truncating division.
    function automatic void model_frame();
        longint sum [DIM];
        int     cnt = 0;
        for (int e = 0; e < DIM; e++) sum[e] = 0;
        for (int t = 0; t < n_tok; t++) begin
            int len;
            len = (t == n_tok - 1) ? last_len : DIM;
            if (fm[t] && cnt < MAXT) begin
                for (int e = 0; e < len; e++) sum[e] += longint'(fv[t][e]);
                if (len == DIM) cnt++;
            end
        end
        exp_tc   = cnt;
        exp_perr = (last_len != DIM);
        for (int e = 0; e < DIM; e++) exp_pooled[e] = (cnt == 0) ? 32'd0 : 32'(sum[e] / longint'(cnt));
        exp_lat = (cnt == 0) ? 1 + DIM : 1 + DIM * (ACCW + 2);
    endfunction

    task automatic send_beats();
        for (int t = 0; t < n_tok; t++) begin
            int len;
            len = (t == n_tok - 1) ? last_len : DIM;
            for (int e = 0; e < len; e++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
                s_valid = 1'b1;
                s_data  = fv[t][e];
                s_mask  = (e == 0) ? fm[t] : 1'($urandom);
                s_last  = (t == n_tok - 1) && (e == len - 1);
                for (int k = 0; k < 50 && s_ready !== 1'b1; k++) begin @(posedge clk); #1; end
                n_cmp++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL s_ready during frame: got %b want 1", s_ready);
                end
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // lat counts cycles from the s_last handshake cycle (=1) to the done cycle.
    task automatic wait_done();
        lat = 1;
        while (done !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("reset: busy=%b done=%b tc=%0d", busy, done, token_count);
        n_cmp++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset s_ready: got %b want 0", s_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
        n_cmp++; if (token_count !== 10'd0) begin n_fail++; $display("FAIL reset token_count: got %0d want 0", token_count); end
        n_cmp++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset protocol_err: got %b want 0", protocol_err); end
        n_cmp++; if (pooled_embedding !== '0) begin n_fail++; $display("FAIL reset pooled: got %h want 0", pooled_embedding); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL idle s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_two_tokens();
        set_tok(0, 2, 4, 6, 8, 1'b1);
        set_tok(1, 4, 8, 10, -12, 1'b1);
        n_tok = 2; last_len = DIM;
        model_frame(); send_beats(); wait_done();
        $display("two_tokens: lat=%0d tc=%0d", lat, token_count);
        n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL two_tokens latency: got %0d want %0d", lat, exp_lat); end
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL two_tokens pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
        n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL two_tokens token_count: got %0d want %0d", token_count, exp_tc); end
        n_cmp++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL two_tokens done width: got %b want 0", done_after); end
    endtask

    task automatic test_masked_middle();
        set_tok(0, 1, 1, 1, 1, 1'b1);
        set_tok(1, 1000, 1000, 1000, 1000, 1'b0);
        set_tok(2, 3, 3, 3, 3, 1'b1);
        n_tok = 3; last_len = DIM;
        model_frame(); send_beats(); wait_done();
        $display("masked_middle: lat=%0d tc=%0d", lat, token_count);
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL masked_middle pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
        n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL masked_middle token_count: got %0d want %0d", token_count, exp_tc); end
    endtask

    task automatic test_truncation();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                set_tok(0, -7, 7, -1, 0, 1'b1);
                set_tok(1, -7, 7, -1, 0, 1'b1);
            end else begin
                set_tok(0, -3, 0, 1, 5, 1'b1);
                set_tok(1, -4, 1, 0, -6, 1'b1);
            end
            n_tok = 2; last_len = DIM;
            model_frame(); send_beats(); wait_done();
            $display("truncation[%0d]: pooled0=%0d tc=%0d", f, $signed(pooled_embedding[0]), token_count);
            for (int i = 0; i < DIM; i++) begin
                n_cmp++;
                if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL truncation[%0d] pooled[%0d]: got %0d want %0d", f, i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
            end
        end
    endtask

    task automatic test_all_masked();
        set_tok(0, 9, 9, 9, 9, 1'b0);
        set_tok(1, -5, 6, 7, 8, 1'b0);
        set_tok(2, 1, 2, 3, 4, 1'b0);
        n_tok = 3; last_len = DIM;
        model_frame(); send_beats(); wait_done();
        $display("all_masked: lat=%0d tc=%0d", lat, token_count);
        n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL all_masked latency: got %0d want %0d", lat, exp_lat); end
        n_cmp++; if (pooled_embedding !== '0) begin n_fail++; $display("FAIL all_masked pooled: got %h want 0", pooled_embedding); end
        n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL all_masked token_count: got %0d want %0d", token_count, exp_tc); end
    endtask

    task automatic test_protocol_err();
        set_tok(0, 4, 4, 4, 4, 1'b1);
        set_tok(1, 8, 8, 99, 99, 1'b1);
        n_tok = 2; last_len = 2;
        model_frame(); send_beats(); wait_done();
        $display("protocol_err: perr=%b tc=%0d", protocol_err, token_count);
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL protocol pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
        n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL protocol token_count: got %0d want %0d", token_count, exp_tc); end
        n_cmp++; if (protocol_err !== exp_perr) begin n_fail++; $display("FAIL protocol protocol_err: got %b want %b", protocol_err, exp_perr); end
    endtask

    task automatic test_back_to_back();
        n_cmp++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL sticky protocol_err: got %b want 1", protocol_err); end
        set_tok(0, 100, -200, 300, -400, 1'b1);
        n_tok = 1; last_len = DIM;
        model_frame(); send_beats(); wait_done();
        $display("back_to_back: perr=%b tc=%0d", protocol_err, token_count);
        n_cmp++; if (protocol_err !== exp_perr) begin n_fail++; $display("FAIL back_to_back protocol_err: got %b want %b", protocol_err, exp_perr); end
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL back_to_back pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
    endtask

    task automatic test_saturation();
        for (int t = 0; t < MAXT + 2; t++) begin
            for (int e = 0; e < DIM; e++) fv[t][e] = ((t * 3 + e) % 11) - 5 + ((t >= MAXT) ? 50000 : 0);
            fm[t] = 1'b1;
        end
        n_tok = MAXT + 2; last_len = DIM;
        model_frame(); send_beats(); wait_done();
        $display("saturation: tc=%0d", token_count);
        n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL saturation token_count: got %0d want %0d", token_count, exp_tc); end
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL saturation pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            n_tok    = int'($urandom_range(1, 6));
            last_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DIM - 1)) : DIM;
            for (int t = 0; t < n_tok; t++) begin
                fm[t] = ($urandom_range(0, 3) != 0);
                for (int e = 0; e < DIM; e++)
                    fv[t][e] = (f % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
            end
            model_frame(); send_beats(); wait_done();
            $display("random[%0d]: ntok=%0d last_len=%0d lat=%0d tc=%0d perr=%b", f, n_tok, last_len, lat, token_count, protocol_err);
            n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL random[%0d] latency: got %0d want %0d", f, lat, exp_lat); end
            n_cmp++; if (token_count !== 10'(exp_tc)) begin n_fail++; $display("FAIL random[%0d] token_count: got %0d want %0d", f, token_count, exp_tc); end
            n_cmp++; if (protocol_err !== exp_perr) begin n_fail++; $display("FAIL random[%0d] protocol_err: got %b want %b", f, protocol_err, exp_perr); end
            for (int i = 0; i < DIM; i++) begin
                n_cmp++;
                if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL random[%0d] pooled[%0d]: got %0d want %0d", f, i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
            end
        end
    endtask

    task automatic test_reset_mid_divide();
        bit seen_done;
        set_tok(0, 9, 9, 9, 9, 1'b1);
        n_tok = 1; last_len = DIM;
        send_beats();
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_divide busy: got %b want 1", busy); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        $display("reset_mid_divide: busy=%b done=%b", busy, done);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_divide reset busy: got %b want 0", busy); end
        n_cmp++; if (pooled_embedding !== '0) begin n_fail++; $display("FAIL mid_divide reset pooled: got %h want 0", pooled_embedding); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_divide reset done: got %b want 0", done); end
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL mid_divide stray done: got %b want 0", seen_done); end
        set_tok(0, 5, 5, 5, 5, 1'b1);
        model_frame(); send_beats(); wait_done();
        $display("after_reset_frame: pooled0=%0d tc=%0d", $signed(pooled_embedding[0]), token_count);
        for (int i = 0; i < DIM; i++) begin
            n_cmp++;
            if (pooled_embedding[i] !== exp_pooled[i]) begin n_fail++; $display("FAIL after_reset pooled[%0d]: got %0d want %0d", i, $signed(pooled_embedding[i]), $signed(exp_pooled[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_two_tokens();
        test_masked_middle();
        test_truncation();
        test_all_masked();
        test_protocol_err();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid_divide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/embedding_mean_pooler.md
Name: embedding_mean_pooler

Overview:
Element-serial attention-masked mean pooling of per-token encoder outputs into one sentence embedding. Sits directly upstream of embedding_normalizer. Its parallel output vector feeds the normalizer's input_embedding, and its done pulse drives the normalizer's start. Data is signed fixed point Q16.16 in 32 bits.

Parameters:
EMBEDDING_DIM, 384, elements per token vector
MAX_TOKENS, 512, maximum counted (unmasked) tokens per frame
ACC_W, 48, accumulator width; must be >= 32 + $clog2(MAX_TOKENS)+1 (elaboration assertion)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_data  in  32  signed Q16.16 element, element index e = beat count mod EMBEDDING_DIM
s_mask  in  1  attention mask of the current token; sampled on beat e==0, ignored on other beats
s_last  in  1  marks final element of final token of the frame
pooled_embedding  out  [EMBEDDING_DIM-1:0][31:0]  mean vector, held until overwritten by next frame's divide
done  out  1  one-cycle pulse when pooled_embedding is complete
busy  out  1  high in P_ACCUM, P_DIVIDE, P_DONE
token_count  out  $clog2(MAX_TOKENS+1)  unmasked tokens counted in the current/last frame
protocol_err  out  1  sticky; cleared only by reset or by the first beat of a new frame

Behaviour:
- Reset (rst_n low at clk edge): state P_IDLE; s_ready=0 during reset; all accumulators, e, token_count, pooled_embedding, done, busy and protocol_err cleared to 0. Reset mid-frame or mid-divide aborts without a done pulse.
- States: P_IDLE, P_ACCUM, P_DIVIDE, P_DONE.
- P_IDLE: s_ready=1. First accepted beat clears protocol_err and token_count, latches mask, processes the beat as in P_ACCUM, and moves to P_ACCUM (or directly to P_DIVIDE if it carries s_last).
- P_ACCUM: s_ready=1. Each accepted beat with the latched mask=1 does acc[e] += sign-extend(s_data). The beat at e==DIM-1 wraps e to 0 and increments token_count if mask=1.
- token_count saturates at MAX_TOKENS; tokens beyond that are treated as masked.
- s_last at e!=DIM-1: set protocol_err, do not count the partial token, terminate the frame. Its partial sums stay accumulated.
- Any accepted s_last → P_DIVIDE on the next cycle.
- P_DIVIDE: s_ready=0. Elements are processed serially, e=0..DIM-1, through sub-module pool_divider.
  - Per element: 1 load cycle, ACC_W restoring iterations on |acc|, 1 writeback cycle, so ACC_W+2 cycles per element.
  - Quotient is truncated toward zero, sign re-applied, and the low 32 bits written to pooled_embedding[e]. The result always fits, since a mean of 32-bit values is within 32-bit range.
  - acc[e] is cleared on load.
  - If token_count==0: skip the divider; write 0 to every element at one element per cycle and clear acc.
- P_DONE: done=1 for exactly one cycle → P_IDLE.
- Latency from the s_last handshake to done: 1 + DIM*(ACC_W+2) cycles, or 1 + DIM cycles when token_count==0.
- s_valid while s_ready=0 is not consumed; the upstream holds data stable.

Decomposition:
- Package rag_pool_pkg: pool_state_t enum, Q16.16 FRAC_BITS=16 constant, the ACC_W minimum-width function.
- Sub-module pool_divider: start/busy/done, signed ACC_W dividend, unsigned divisor, 32-bit quotient. This is the sequential restoring divider.

Test Plan:
(Bench uses EMBEDDING_DIM=4, raw integer values.)
- Two tokens mask=1: [2,4,6,8] then [4,8,10,-12] with s_last on the final beat → pooled=[3,6,8,-2], token_count=2, done after 1+4*50 cycles.
- Three tokens, middle mask=0 with values [1000,1000,1000,1000]: [1,1,1,1], masked, [3,3,3,3] → pooled=[2,2,2,2], token_count=2.
- Single token [-7,7,-1,0] repeated twice with sums -14 and 14, and a separate case of sum -7 over 2 tokens → truncation gives -3 (not -4).
- All tokens masked → pooled all 0, token_count=0, done after 1+4 cycles.
- s_last at e=1 after one full token [4,4,4,4] followed by partial [8,8] → protocol_err=1, token_count=1, pooled=[12,12,4,4].
- Reset asserted mid-P_DIVIDE: the following cycle shows busy=0, pooled=0 and no done pulse. A new frame [5,5,5,5] then yields [5,5,5,5], confirming acc was cleared.
